// File: rtl/ysyx_22040895_bru_if.sv
// Request/result bundle between the EXU operand stage and the branch resolution unit.
// master = requester and result consumer, slave = the BRU.
interface ysyx_22040895_bru_if #(
    parameter int XLEN = 64
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      bcuop_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] offset_i;
    logic            pred_taken_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_pc_o;
    logic            out_taken_o;
    logic [XLEN-1:0] out_target_o;
    logic            out_redirect_o;
    logic [XLEN-1:0] out_redir_pc_o;

    modport master (
        output in_valid_i, bcuop_i, src1_i, src2_i, pc_i, offset_i, pred_taken_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_taken_o, out_target_o,
               out_redirect_o, out_redir_pc_o
    );

    modport slave (
        input  in_valid_i, bcuop_i, src1_i, src2_i, pc_i, offset_i, pred_taken_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_taken_o, out_target_o,
               out_redirect_o, out_redir_pc_o
    );
endinterface

// File: rtl/ysyx_22040895_bru.sv
// Branch resolution unit: compares operands, checks the fetch prediction, registers the
// result behind a one-entry valid/ready stage and trains a BHT of 2-bit saturating counters.
module ysyx_22040895_bru #(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 16,
    parameter int OFF_SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    ysyx_22040895_bru_if.slave    bus,
    input  logic [XLEN-1:0]       lkp_pc_i,
    output logic                  lkp_taken_o,
    output logic [31:0]           mispred_cnt_o
);
    localparam int IDX = $clog2(BHT_DEPTH);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic            taken_q;
    logic [XLEN-1:0] target_q;
    logic            redirect_q;
    logic [XLEN-1:0] redir_pc_q;
    logic [31:0]     cnt_q;
    logic [1:0]      bht_q [BHT_DEPTH];

    logic            in_ready;
    logic            accept;
    logic            is_br;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic            taken_d;
    logic            redirect_d;
    logic [XLEN-1:0] target_d;
    logic [XLEN-1:0] pc4_d;
    logic [XLEN-1:0] redir_pc_d;
    logic [IDX-1:0]  upd_idx;
    logic [IDX-1:0]  lkp_idx;
    logic            lkp_unused;

    assign in_ready = ~flush_i & (~valid_q | bus.out_ready_i);
    assign accept   = bus.in_valid_i & in_ready;

    assign eq  = bus.src1_i == bus.src2_i;
    assign lt  = $signed(bus.src1_i) < $signed(bus.src2_i);
    assign ltu = bus.src1_i < bus.src2_i;

    always_comb begin
        is_br   = 1'b1;
        taken_d = 1'b0;
        case (bus.bcuop_i)
            3'b001:  taken_d = eq;
            3'b010:  taken_d = ~lt;
            3'b011:  taken_d = ~ltu;
            3'b100:  taken_d = lt;
            3'b101:  taken_d = ltu;
            3'b110:  taken_d = ~eq;
            default: is_br   = 1'b0;
        endcase
    end

    // Both sums wrap modulo 2^XLEN by construction of the operand width.
    assign target_d   = bus.pc_i + (bus.offset_i << OFF_SHIFT);
    assign pc4_d      = bus.pc_i + XLEN'(4);
    assign redirect_d = is_br & (taken_d != bus.pred_taken_i);
    assign redir_pc_d = taken_d ? target_d : pc4_d;

    assign upd_idx    = bus.pc_i[IDX+1:2];
    assign lkp_idx    = lkp_pc_i[IDX+1:2];
    assign lkp_unused = ^{lkp_pc_i[XLEN-1:IDX+2], lkp_pc_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            taken_q    <= 1'b0;
            target_q   <= '0;
            redirect_q <= 1'b0;
            redir_pc_q <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (bus.out_ready_i) begin
                valid_q <= 1'b0;
            end

            if (accept) begin
                pc_q       <= bus.pc_i;
                taken_q    <= taken_d;
                target_q   <= target_d;
                redirect_q <= redirect_d;
                redir_pc_q <= redir_pc_d;
                if (redirect_d && cnt_q != 32'hFFFF_FFFF) begin
                    cnt_q <= cnt_q + 32'd1;
                end
                if (is_br) begin
                    if (taken_d) begin
                        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
                    end else begin
                        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
                    end
                end
            end
        end
    end

    assign bus.in_ready_o     = in_ready;
    assign bus.out_valid_o    = valid_q;
    assign bus.out_pc_o       = pc_q;
    assign bus.out_taken_o    = taken_q;
    assign bus.out_target_o   = target_q;
    assign bus.out_redirect_o = redirect_q;
    assign bus.out_redir_pc_o = redir_pc_q;
    assign lkp_taken_o        = bht_q[lkp_idx][1];
    assign mispred_cnt_o      = cnt_q;
endmodule

// File: tb/tb_ysyx_22040895_bru.sv
// Bench for the branch resolution unit: a transaction-level model checked every cycle,
// plus directed vectors with literal expectations.
module tb_ysyx_22040895_bru;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [63:0] lkp_pc_i = '0;
    logic        lkp_taken_o;
    logic [31:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;

    ysyx_22040895_bru_if #(.XLEN(64)) bus ();

    ysyx_22040895_bru #(.XLEN(64), .BHT_DEPTH(16), .OFF_SHIFT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .bus           (bus),
        .lkp_pc_i      (lkp_pc_i),
        .lkp_taken_o   (lkp_taken_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the result the consumer should see, the BHT, the counter.
    logic        m_valid;
    logic [63:0] m_pc, m_target, m_redir_pc;
    logic        m_taken, m_redirect;
    logic [31:0] m_cnt;
    int          m_bht [16];

    function automatic logic m_ready();
        return !flush_i && (!m_valid || bus.out_ready_i);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_pc = 0; m_target = 0; m_redir_pc = 0;
            m_taken = 0; m_redirect = 0; m_cnt = 0;
            foreach (m_bht[i]) m_bht[i] = 1;
        end else begin
            logic acc, br, tk;
            logic [63:0] a, b;
            int ix;
            acc = bus.in_valid_i && m_ready();
            if (acc) begin
                a = bus.src1_i; b = bus.src2_i; br = 1;
                case (bus.bcuop_i)
                    3'd1:    tk = (a == b);
                    3'd2:    tk = ($signed(a) >= $signed(b));
                    3'd3:    tk = (a >= b);
                    3'd4:    tk = ($signed(a) < $signed(b));
                    3'd5:    tk = (a < b);
                    3'd6:    tk = (a != b);
                    default: begin tk = 0; br = 0; end
                endcase
                m_pc       = bus.pc_i;
                m_taken    = tk;
                m_target   = bus.pc_i + bus.offset_i * 2;
                m_redirect = br && (tk != bus.pred_taken_i);
                m_redir_pc = tk ? m_target : bus.pc_i + 4;
                if (m_redirect && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                ix = int'(bus.pc_i[5:2]);
                if (br) m_bht[ix] = tk ? (m_bht[ix] == 3 ? 3 : m_bht[ix] + 1)
                                       : (m_bht[ix] == 0 ? 0 : m_bht[ix] - 1);
            end
            if (flush_i)               m_valid = 0;
            else if (acc)              m_valid = 1;
            else if (bus.out_ready_i)  m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 64'(bus.out_valid_o), 64'(m_valid));
            chk("in_ready", 64'(bus.in_ready_o), 64'(m_ready()));
            chk("mispred_cnt", 64'(mispred_cnt_o), 64'(m_cnt));
            chk("lkp_taken", 64'(lkp_taken_o), 64'(m_bht[int'(lkp_pc_i[5:2])] >= 2));
            if (m_valid) begin
                chk("out_pc", bus.out_pc_o, m_pc);
                chk("out_taken", 64'(bus.out_taken_o), 64'(m_taken));
                chk("out_target", bus.out_target_o, m_target);
                chk("out_redirect", 64'(bus.out_redirect_o), 64'(m_redirect));
                chk("out_redir_pc", bus.out_redir_pc_o, m_redir_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                       input logic [63:0] pc, input logic [63:0] off, input logic pred);
        bus.in_valid_i = 1; bus.bcuop_i = op; bus.src1_i = s1; bus.src2_i = s2;
        bus.pc_i = pc; bus.offset_i = off; bus.pred_taken_i = pred;
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                        input logic [63:0] pc, input logic [63:0] off, input logic pred);
        req(op, s1, s2, pc, off, pred);
        step();
        bus.in_valid_i = 0;
    endtask

    initial begin
        bus.in_valid_i = 0; bus.bcuop_i = 0; bus.src1_i = 0; bus.src2_i = 0;
        bus.pc_i = 0; bus.offset_i = 0; bus.pred_taken_i = 0; bus.out_ready_i = 1;
        #12 rst = 0;
        step();

        // Reset state and weakly-not-taken BHT everywhere.
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_cnt", 64'(mispred_cnt_o), 64'd0);
        for (int i = 0; i < 16; i++) begin
            lkp_pc_i = 64'(i * 4);
            #0.1;
            chk("rst_lkp", 64'(lkp_taken_o), 64'd0);
        end
        lkp_pc_i = 64'h8000_0000;

        // beq taken, predicted not-taken.
        send(3'b001, 64'd5, 64'd5, 64'h8000_0000, 64'h10, 1'b0);
        chk("beq_valid", 64'(bus.out_valid_o), 64'd1);
        chk("beq_taken", 64'(bus.out_taken_o), 64'd1);
        chk("beq_target", bus.out_target_o, 64'h8000_0020);
        chk("beq_redirect", 64'(bus.out_redirect_o), 64'd1);
        chk("beq_redir_pc", bus.out_redir_pc_o, 64'h8000_0020);
        chk("beq_cnt", 64'(mispred_cnt_o), 64'd1);
        step();
        chk("drain_valid", 64'(bus.out_valid_o), 64'd0);

        // Signed vs unsigned compare, back-to-back.
        req(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'h8, 1'b1);
        step();
        chk("blt_taken", 64'(bus.out_taken_o), 64'd1);
        chk("blt_redirect", 64'(bus.out_redirect_o), 64'd0);
        req(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'h8, 1'b1);
        step();
        bus.in_valid_i = 0;
        chk("bltu_taken", 64'(bus.out_taken_o), 64'd0);
        chk("bltu_redir_pc", bus.out_redir_pc_o, 64'h104);
        chk("bltu_cnt", 64'(mispred_cnt_o), 64'd2);

        // Remaining ops and a non-branch op.
        send(3'b010, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h200, 64'h4, 1'b1);
        send(3'b011, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h204, 64'h4, 1'b0);
        send(3'b110, 64'd7, 64'd7, 64'h208, 64'h4, 1'b0);
        send(3'b000, 64'd7, 64'd7, 64'h20C, 64'h4, 1'b1);
        chk("nop_taken", 64'(bus.out_taken_o), 64'd0);
        chk("nop_redirect", 64'(bus.out_redirect_o), 64'd0);
        chk("nop_redir_pc", bus.out_redir_pc_o, 64'h210);
        send(3'b111, 64'd1, 64'd2, 64'h210, 64'h4, 1'b1);
        step();

        // Backpressure: result A held while B waits.
        bus.out_ready_i = 0;
        send(3'b001, 64'd1, 64'd2, 64'h300, 64'h4, 1'b0);
        req(3'b110, 64'd1, 64'd2, 64'h400, 64'h4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            chk("bp_hold_pc", bus.out_pc_o, 64'h300);
            step();
        end
        bus.out_ready_i = 1;
        step();
        bus.in_valid_i = 0;
        chk("bp_second_pc", bus.out_pc_o, 64'h400);
        chk("bp_second_taken", 64'(bus.out_taken_o), 64'd1);

        // Asynchronous reset in the middle of a cycle with a result in flight.
        #2 rst = 1;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("async_rst_cnt", 64'(mispred_cnt_o), 64'd0);
        #3 rst = 0;
        step();

        // BHT training at pc 0x40.
        lkp_pc_i = 64'h40;
        send(3'b001, 64'd9, 64'd9, 64'h40, 64'h4, 1'b1);
        chk("bht_10", 64'(lkp_taken_o), 64'd1);
        req(3'b001, 64'd9, 64'd9, 64'h40, 64'h4, 1'b1);
        chk("bht_rbw", 64'(lkp_taken_o), 64'd1);
        step();
        send(3'b001, 64'd9, 64'd9, 64'h40, 64'h4, 1'b1);
        chk("bht_11", 64'(lkp_taken_o), 64'd1);
        send(3'b001, 64'd9, 64'd8, 64'h40, 64'h4, 1'b1);
        chk("bht_nt", 64'(lkp_taken_o), 64'd1);
        send(3'b001, 64'd9, 64'd8, 64'h40, 64'h4, 1'b1);
        chk("bht_01", 64'(lkp_taken_o), 64'd0);
        step();

        // Wrap-around target.
        send(3'b001, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8, 1'b1);
        chk("wrap_target", bus.out_target_o, 64'h0);
        chk("wrap_redir_pc", bus.out_redir_pc_o, 64'h0);

        // Flush with a pending request: nothing accepted, nothing trained.
        lkp_pc_i = 64'h44;
        flush_i = 1;
        req(3'b110, 64'd1, 64'd2, 64'h44, 64'h4, 1'b0);
        #0.1;
        chk("flush_in_ready", 64'(bus.in_ready_o), 64'd0);
        step();
        flush_i = 0;
        bus.in_valid_i = 0;
        chk("flush_valid", 64'(bus.out_valid_o), 64'd0);
        chk("flush_cnt", 64'(mispred_cnt_o), 64'd2);
        chk("flush_lkp", 64'(lkp_taken_o), 64'd0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
